// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Streams a program image from a byte-wide valid/ready source into the
// instruction memory write port. The core is held in reset until the whole
// image has been written and, when enabled, checked.
//
// Stream format (little-endian throughout):
//    4 bytes  : word count N
//    4*N bytes: instruction words, first byte -> bits 7:0
//    1 byte   : XOR checksum of all payload bytes (only with the macro below)
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//    defined   -> trailing checksum byte is checked before the core is released
//    undefined -> no checksum state or register; done follows the last word
//
// Parameters:
//    DEPTH_WORDS : imem capacity in 32-bit words; larger lengths are rejected
//    BASE_ADDR   : byte address of the first word (4-byte aligned)
//
// Ports:
//    clk         in   system clock
//    rst_n       in   asynchronous active-low reset
//    in_valid    in   source presents a byte on in_data
//    in_data     in   stream byte
//    in_ready    out  loader accepts the byte this cycle
//    mem_we      out  imem write strobe, one cycle per word
//    mem_addr    out  imem byte address of the word being written
//    mem_wdata   out  assembled instruction word
//    core_rst_n  out  active-low reset to the core
//    done        out  load finished successfully (sticky)
//    error       out  load rejected (sticky)
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_rst_n,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM = 3'd2,
`endif
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   // State that follows the payload (or an empty length field).
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_PAYLOAD = S_CSUM;
`else
   localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] len_q, len_d;
   logic [31:0] word_idx_q, word_idx_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        core_rst_n_q, core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        in_ready_s;
   logic        accept_s;
   logic        last_byte_s;
   logic        last_word_s;
   logic [31:0] full_word_s;

   // Shift register holds the first three bytes; the fourth arrives on in_data,
   // so the complete little-endian word is available at the accepting edge.
   assign full_word_s = {in_data, shift_q};
   assign accept_s    = in_valid & in_ready_s;
   assign last_byte_s = (byte_cnt_q == 2'd3);
   assign last_word_s = ((word_idx_q + 32'd1) == len_q);

   // State register and all datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_LEN;
         byte_cnt_q   <= 2'd0;
         shift_q      <= 24'd0;
         len_q        <= 32'd0;
         word_idx_q   <= 32'd0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= 32'd0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         len_q        <= len_d;
         word_idx_q   <= word_idx_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_rst_n_q <= core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN: begin
            if (accept_s && last_byte_s) begin
               if (full_word_s > DEPTH_L) begin
                  state_d = S_ERR;
               end else if (full_word_s == 32'd0) begin
                  state_d = AFTER_PAYLOAD;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_DATA: begin
            if (accept_s && last_byte_s && last_word_s) begin
               state_d = AFTER_PAYLOAD;
            end else begin
               state_d = state_q;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept_s) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end else begin
               state_d = state_q;
            end
         end
`endif
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         // An unreachable encoding is treated as a failed load.
         default: state_d = S_ERR;
      endcase
   end

   // Byte assembly, length capture, word index and checksum accumulation.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      if (accept_s && ((state_q == S_LEN) || (state_q == S_DATA))) begin
         // 2-bit counter wraps 3 -> 0, so it is ready for the next word.
         byte_cnt_d = byte_cnt_q + 2'd1;
         shift_d    = full_word_s[31:8];
         if (last_byte_s && (state_q == S_LEN)) begin
            len_d = full_word_s;
         end else begin
            len_d = len_q;
         end
         if (last_byte_s && (state_q == S_DATA)) begin
            word_idx_d = word_idx_q + 32'd1;
         end else begin
            word_idx_d = word_idx_q;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (state_q == S_DATA) begin
            csum_d = csum_q ^ in_data;
         end else begin
            csum_d = csum_q;
         end
`endif
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Output logic: in_ready is combinational, everything else is registered.
   always_comb begin
      in_ready_s   = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         S_LEN:   in_ready_s = rst_n;
         S_DATA:  in_ready_s = rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:  in_ready_s = rst_n;
`endif
         default: in_ready_s = 1'b0;
      endcase
      if (in_valid && in_ready_s && (state_q == S_DATA) && last_byte_s) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = BASE_ADDR + (word_idx_q << 2);
         mem_wdata_d = full_word_s;
      end else begin
         mem_we_d    = 1'b0;
      end
      // done/core release lag S_DONE entry by one cycle, so they rise only
      // after the final write strobe has been presented to imem.
      done_d       = done_q | (state_q == S_DONE);
      core_rst_n_d = core_rst_n_q | (state_q == S_DONE);
      error_d      = error_q | (state_d == S_ERR);
   end

   assign in_ready   = in_ready_s;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction memory fetch path: streams a program image into imem over a byte-wide valid/ready interface.
- Holds the core in reset until the image is complete.
- Replaces the simulation-only hex preload with a synthesizable load path driven by a UART or debug bridge.
- Sits between the host byte source and the imem write port. It drives the core's rst_n.

Parameters:
- DEPTH_WORDS, 1024: imem capacity in 32-bit words; any length above this is rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be 4-byte aligned.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source has a byte on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts the byte this cycle
- mem_we  output  1  imem write strobe, one cycle per word
- mem_addr  output  32  imem byte address, word aligned
- mem_wdata  output  32  assembled instruction word
- core_rst_n  output  1  active-low reset to core
- done  output  1  load finished successfully, sticky
- error  output  1  load rejected, sticky

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk.
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_rst_n=0, done=0, error=0. FSM goes to S_LEN; all counters are 0.
- A byte is accepted on a rising edge where in_valid && in_ready. in_ready=1 combinationally in S_LEN, S_DATA and S_CSUM; it is 0 in S_DONE and S_ERR.
- Stream format: 4-byte word count N, little-endian. Then N words, each 4 bytes little-endian (first byte → bits 7:0). Then one checksum byte only when IMEM_LOADER_CHECKSUM_EN is defined.
- S_LEN: collect 4 bytes into len.
  - After the 4th byte: if len > DEPTH_WORDS → S_ERR.
  - Else if len == 0 → S_CSUM when the feature is enabled, otherwise S_DONE.
  - Else → S_DATA.
- S_DATA: byte counter 0..3 assembles the word.
  - On acceptance of byte 3 of word i, at the same edge: mem_we=1, mem_addr=BASE_ADDR+4*i, mem_wdata=assembled word. mem_we drops the following cycle unless another word completes.
  - After word N-1 → S_CSUM when the feature is enabled, otherwise S_DONE.
  - Back-to-back bytes every cycle are supported with no bubbles.
  - The word index counter is 32 bits wide. No wrap is possible because N ≤ DEPTH_WORDS.
- S_DONE: done=1 and core_rst_n=1, registered. Both rise one cycle after the final mem_we pulse (or one cycle after the length's last byte when N=0). The core never fetches before its last word is written. The state is held until rst_n.
- S_ERR: error=1 is registered on entry. core_rst_n stays 0, no further writes occur, in_ready=0. The state is held until rst_n.
- done and error are never both 1.
- Stalls: in_valid low for any number of cycles pauses the FSM with no state change. Partial word bytes and the byte counter are retained.
- Reset mid-load: all outputs return to reset values immediately, including an in-flight mem_we, which is forced to 0 asynchronously. The next load restarts at the length field.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is kept; length bytes are excluded, and the initial value is 8'h00.
  - S_CSUM accepts one byte. If it equals the running XOR → S_DONE; otherwise → S_ERR.
  - Words are still written before the check; on mismatch core_rst_n stays 0, so the bad image never executes.
- Undefined: no S_CSUM state and no XOR register. S_DONE is entered directly after the last word (or after the length when N=0).

Test Plan:
- Load N=2, words 32'h00500093 and 32'h00A00113, no stalls → mem_we pulses twice, at mem_addr 0x0 then 0x4 with those data; done=1 and core_rst_n=1 one cycle after the second pulse; in_ready=0 afterwards.
- Same image with in_valid deasserted 3 cycles between every byte → identical write sequence and values; no extra mem_we pulses.
- Length bytes encoding DEPTH_WORDS+1 (e.g. 1025 = 01 04 00 00) → error=1, no mem_we pulse, core_rst_n=0, in_ready=0.
- N=0 → no writes; done=1 one cycle after the 4th length byte (feature off).
- Assert rst_n=0 after 2 bytes of word 1 and then reload N=1, word 32'hDEADBEEF → single write of 0xDEADBEEF at address 0x0; no stale partial bytes.
- IMEM_LOADER_CHECKSUM_EN on, N=1, word bytes 13 05 50 00, checksum 0x46 → done=1; repeat with checksum 0x47 → one write occurs, then error=1 and core_rst_n=0.
